pe_axis_feeder: RTL and testbench
=================================

# pe_axis_feeder

Operand feeder sitting upstream of a multiply–accumulate PE. It buffers two independent AXI4-Stream operand sources (A, B) and a job command stream. Per job it issues one configuration word on the PE config port, then exactly `len` operand pairs on the PE north (A) and west (B) input ports. Each port has its own independent AXI4-Stream handshake, so it works against any PE ready policy.

## Interface
- `WIDTH`, 32: operand and config word width (IEEE-754 single).
- `DEPTH`, 4: entries per operand FIFO; a power of two, ≥2.
- `LEN_W`, 16: width of the job length and the pair counter.

- `aclk`, in, 1: clock. One clock domain only.
- `areset`, in, 1: reset, synchronous, active-high.
- `a_tdata` / `a_tvalid` / `a_tready`, in/in/out, WIDTH/1/1: source A operand stream.
- `b_tdata` / `b_tvalid` / `b_tready`, in/in/out, WIDTH/1/1: source B operand stream.
- `cmd_len` / `cmd_coef` / `cmd_valid` / `cmd_ready`, in/in/in/out, LEN_W/WIDTH/1/1: job command (pair count, config word).
- `n_tdata` / `n_tvalid` / `n_tready`, out/out/in, WIDTH/1/1: to PE north input (A operands).
- `w_tdata` / `w_tvalid` / `w_tready`, out/out/in, WIDTH/1/1: to PE west input (B operands).
- `cfg_tdata` / `cfg_tvalid` / `cfg_tready`, out/out/in, WIDTH/1/1: to PE config port.
- `busy`, out, 1: high when not in IDLE.
- `done`, out, 1: one-cycle pulse at job completion.
- `pair_cnt`, out, LEN_W: pairs completed in the current job.

## Operation
- **FSM states:** IDLE, CFG, STREAM.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `len` and `coef`, clear `pair_cnt`, then go to CFG.
- **CFG:**
  - `cfg_tvalid`=1 and `cfg_tdata`=`coef`, both held until `cfg_tready`.
  - On handshake: go to STREAM if `len`≠0; if `len`=0, pulse `done` and go to IDLE.
- **STREAM, north side:**
  - `n_tvalid` = FIFO A not empty AND `n_sent`=0.
  - `n_tdata` = FIFO A head.
  - A north handshake pops FIFO A and sets `n_sent`.
- **STREAM, west side:** symmetric to the north side, using FIFO B, `w_tvalid`, `w_tdata` and `w_sent`.
- **Pair completion:**
  - A pair completes in the cycle where both sides have transferred, whether in the same cycle or in different cycles.
  - On completion: clear `n_sent`/`w_sent` and increment `pair_cnt`.
  - If the completing pair is number `len`: pulse `done` and go to IDLE.
- **Handshake stability:**
  - Once asserted, `*_tvalid` and `*_tdata` stay stable until their handshake.
  - No valid depends combinationally on its own ready.
- **FIFOs:**
  - They accept data in every state, so they prefetch while IDLE/CFG.
  - `a_tready` = FIFO A not full; `b_tready` likewise for FIFO B.
  - No write when full, and no bypass of a full FIFO.
  - Pointers wrap modulo DEPTH; the occupancy count is `$clog2(DEPTH)+1` bits wide.
  - When not full, a simultaneous push and pop in the same cycle keeps the count unchanged.
- **Outside STREAM:** `n_tvalid`=`w_tvalid`=0.
- **Reset:**
  - Clears the FSM to IDLE, the FIFOs to empty, `n_sent`, `w_sent` and `pair_cnt`.
  - Reset values: all `*_tvalid`=0, `done`=0, `busy`=0, `pair_cnt`=0, all `*_tdata`=0.
  - While `areset` is high: `a_tready`, `b_tready` and `cmd_ready` are 0.
  - Reset asserted mid-job abandons the job without a `done` pulse.

## Timing
- Command accepted at edge t → `cfg_tvalid` high in cycle t+1.
- cfg handshake at cycle c → STREAM from c+1; the first pair can transfer at c+1.
- Source word accepted at edge t → visible at the FIFO head in cycle t+1.
- Throughput: sustained one pair per cycle with both readies high and the FIFOs non-empty.
- `done` is high in the cycle after the final pair handshake. That cycle is IDLE with `cmd_ready`=1, so back-to-back jobs are possible.

## Structure
- **Package `pe_pkg`:**
  - `feed_state_t` enum {IDLE, CFG, STREAM}.
  - Default `WIDTH` and `LEN_W` localparams.
- **Sub-module `pe_feed_fifo`:** synchronous FIFO with a valid/ready interface and a registered head; instantiated twice (A, B).

## Test plan
- **Reset:** hold `areset` 2 cycles → all valids 0; `cmd_ready`/`a_tready`/`b_tready` 0 during reset and 1 in the first cycle after it.
- **Nominal job:** preload A=1..4, B=10,20,30,40; command `len`=4, `coef`=0x3F800000; all readies high → cfg word one cycle after acceptance; pairs (1,10)…(4,40) on 4 consecutive cycles; `done` one cycle after; `pair_cnt`=4.
- **Skewed readiness:** A=5/B=50; `w_tready` low 3 cycles, `n_tready` high → north transfers once and `n_tvalid` drops; `w_tdata`=50 is held; `pair_cnt` increments only on the west handshake.
- **FIFO full:** 4 A words, no job → `a_tready` low from the cycle after the 4th accept; a 5th word is held upstream; pop one → it is accepted.
- **Empty job:** `len`=0 → cfg transfers; `done` the next cycle; no `n_tvalid`/`w_tvalid` ever asserted.
- **Reset mid-job:** `len`=4, reset after 2 pairs → next cycle IDLE, FIFOs empty, no `done`; a new `len`=1 job then completes normally.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE operand feeder.
//   feed_state_t : feeder FSM states (IDLE, CFG, STREAM)
//   DEF_WIDTH    : default operand/config word width (IEEE-754 single)
//   DEF_LEN_W    : default width of job length and pair counter
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    STREAM = 2'd2
  } feed_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LEN_W = 16;

endpackage

// File: rtl/pe_feed_fifo.sv
// Synchronous valid/ready FIFO used to buffer one operand source.
// The head word comes straight out of a storage register, so a word written
// at edge t is visible at the head in cycle t+1 and never bypasses storage.
// Ports:
//   clk, srst                       : clock, synchronous active-high reset
//   in_data/in_valid/in_ready       : write side (in_ready low while full or in reset)
//   out_data/out_valid/out_ready    : read side (out_data = head word)
module pe_feed_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic full;
  logic push;
  logic pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign in_ready  = !full && !srst;
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_reg[rd_ptr_reg];

  // Storage entries are cleared on reset so the head reads zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (srst) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= in_data;
      end
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_axis_feeder.sv
// Operand feeder for a multiply-accumulate PE.
// Buffers A and B operand streams, accepts job commands, and per job sends
// one config word followed by exactly len (A,B) pairs on the north/west ports.
// Ports:
//   aclk, areset                          : clock, synchronous active-high reset
//   a_* / b_*                             : AXI4-Stream operand sources
//   cmd_len/cmd_coef/cmd_valid/cmd_ready  : job command
//   n_* / w_*                             : PE north (A) / west (B) outputs
//   cfg_*                                 : PE config word output
//   busy, done, pair_cnt                  : job status
module pe_axis_feeder
  import pe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] a_tdata,
  input  logic             a_tvalid,
  output logic             a_tready,
  input  logic [WIDTH-1:0] b_tdata,
  input  logic             b_tvalid,
  output logic             b_tready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_coef,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] n_tdata,
  output logic             n_tvalid,
  input  logic             n_tready,
  output logic [WIDTH-1:0] w_tdata,
  output logic             w_tvalid,
  input  logic             w_tready,
  output logic [WIDTH-1:0] cfg_tdata,
  output logic             cfg_tvalid,
  input  logic             cfg_tready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pair_cnt
);

  feed_state_t      state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [WIDTH-1:0] coef_reg;
  logic [LEN_W-1:0] pair_cnt_reg;
  logic             n_sent_reg;
  logic             w_sent_reg;
  logic             done_reg;

  logic             a_avail;
  logic             b_avail;
  logic             in_stream;
  logic             n_fire;
  logic             w_fire;
  logic             pair_done;
  logic [LEN_W-1:0] pair_cnt_inc;

  assign in_stream = (state_reg == STREAM);

  // Each side may send at most one word per pair; its sent flag blocks a
  // second word until the other side catches up.
  assign n_tvalid = in_stream && a_avail && !n_sent_reg;
  assign w_tvalid = in_stream && b_avail && !w_sent_reg;
  assign n_fire   = n_tvalid && n_tready;
  assign w_fire   = w_tvalid && w_tready;

  // A pair closes when both sides have transferred, now or earlier.
  assign pair_done    = (n_sent_reg || n_fire) && (w_sent_reg || w_fire);
  assign pair_cnt_inc = pair_cnt_reg + 1'b1;

  assign cmd_ready  = (state_reg == IDLE) && !areset;
  assign cfg_tvalid = (state_reg == CFG);
  assign cfg_tdata  = coef_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign pair_cnt   = pair_cnt_reg;

  pe_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (aclk),
    .srst      (areset),
    .in_data   (a_tdata),
    .in_valid  (a_tvalid),
    .in_ready  (a_tready),
    .out_data  (n_tdata),
    .out_valid (a_avail),
    .out_ready (n_fire)
  );

  pe_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (aclk),
    .srst      (areset),
    .in_data   (b_tdata),
    .in_valid  (b_tvalid),
    .in_ready  (b_tready),
    .out_data  (w_tdata),
    .out_valid (b_avail),
    .out_ready (w_fire)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      coef_reg     <= '0;
      pair_cnt_reg <= '0;
      n_sent_reg   <= 1'b0;
      w_sent_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            len_reg      <= cmd_len;
            coef_reg     <= cmd_coef;
            pair_cnt_reg <= '0;
            state_reg    <= CFG;
          end
        end
        CFG: begin
          if (cfg_tready) begin
            if (len_reg == '0) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              state_reg <= STREAM;
            end
          end
        end
        STREAM: begin
          if (pair_done) begin
            n_sent_reg   <= 1'b0;
            w_sent_reg   <= 1'b0;
            pair_cnt_reg <= pair_cnt_inc;
            if (pair_cnt_inc == len_reg) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            n_sent_reg <= n_sent_reg || n_fire;
            w_sent_reg <= w_sent_reg || w_fire;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_axis_feeder.sv
// Directed bench for pe_axis_feeder. Inputs are driven and outputs sampled on
// the falling clock edge; handshakes therefore resolve on the rising edge.
module tb_pe_axis_feeder;

  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  logic             aclk = 1'b0;
  logic             areset;
  logic [WIDTH-1:0] a_tdata, b_tdata, cmd_coef;
  logic             a_tvalid, b_tvalid, cmd_valid;
  logic             a_tready, b_tready, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] n_tdata, w_tdata, cfg_tdata;
  logic             n_tvalid, w_tvalid, cfg_tvalid;
  logic             n_tready, w_tready, cfg_tready;
  logic             busy, done;
  logic [LEN_W-1:0] pair_cnt;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  pe_axis_feeder #(.WIDTH(WIDTH), .DEPTH(4), .LEN_W(LEN_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .a_tdata    (a_tdata),
    .a_tvalid   (a_tvalid),
    .a_tready   (a_tready),
    .b_tdata    (b_tdata),
    .b_tvalid   (b_tvalid),
    .b_tready   (b_tready),
    .cmd_len    (cmd_len),
    .cmd_coef   (cmd_coef),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .n_tdata    (n_tdata),
    .n_tvalid   (n_tvalid),
    .n_tready   (n_tready),
    .w_tdata    (w_tdata),
    .w_tvalid   (w_tvalid),
    .w_tready   (w_tready),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .busy       (busy),
    .done       (done),
    .pair_cnt   (pair_cnt)
  );

  // Offer one word on source A and hold it until accepted (bounded wait).
  task automatic push_a(input logic [WIDTH-1:0] v);
    int n = 0;
    a_tdata  = v;
    a_tvalid = 1'b1;
    while (!a_tready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    total++;
    if (a_tready !== 1'b1) begin
      bad++;
      $display("FAIL push_a_timeout word=%0d a_tready=%b required=1", v, a_tready);
    end
    @(negedge aclk);
    a_tvalid = 1'b0;
  endtask

  task automatic push_b(input logic [WIDTH-1:0] v);
    int n = 0;
    b_tdata  = v;
    b_tvalid = 1'b1;
    while (!b_tready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    total++;
    if (b_tready !== 1'b1) begin
      bad++;
      $display("FAIL push_b_timeout word=%0d b_tready=%b required=1", v, b_tready);
    end
    @(negedge aclk);
    b_tvalid = 1'b0;
  endtask

  // Present a command for one cycle; the DUT must be in IDLE.
  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] coef);
    cmd_len   = len;
    cmd_coef  = coef;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready got=%b want=1", cmd_ready);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    a_tvalid = 0; b_tvalid = 0; cmd_valid = 0;
    a_tdata = 0; b_tdata = 0; cmd_len = 0; cmd_coef = 0;
    n_tready = 0; w_tready = 0; cfg_tready = 0;
    @(negedge aclk);
    @(negedge aclk);
    total++;
    if ({cmd_ready, a_tready, b_tready} !== 3'b000) begin
      bad++;
      $display("FAIL reset_readies got=%b want=000", {cmd_ready, a_tready, b_tready});
    end
    total++;
    if ({n_tvalid, w_tvalid, cfg_tvalid, busy, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valids got=%b want=00000", {n_tvalid, w_tvalid, cfg_tvalid, busy, done});
    end
    total++;
    if (pair_cnt !== 0 || n_tdata !== 0 || w_tdata !== 0 || cfg_tdata !== 0) begin
      bad++;
      $display("FAIL reset_data pair_cnt=%0d n=%0h w=%0h cfg=%0h want all 0", pair_cnt, n_tdata, w_tdata, cfg_tdata);
    end
    areset = 1'b0;
    @(negedge aclk);
    total++;
    if ({cmd_ready, a_tready, b_tready} !== 3'b111) begin
      bad++;
      $display("FAIL post_reset_readies got=%b want=111", {cmd_ready, a_tready, b_tready});
    end
    $display("reset: readies=%b", {cmd_ready, a_tready, b_tready});
  endtask

  task automatic test_nominal();
    n_tready = 1; w_tready = 1; cfg_tready = 1;
    for (int i = 1; i <= 4; i++) push_a(i);
    for (int i = 1; i <= 4; i++) push_b(10 * i);
    send_cmd(4, 32'h3F80_0000);
    total++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== 32'h3F80_0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_cfg valid=%b data=%h busy=%b want 1/3f800000/1", cfg_tvalid, cfg_tdata, busy);
    end
    @(negedge aclk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (n_tvalid !== 1'b1 || w_tvalid !== 1'b1 || n_tdata !== k + 1 ||
          w_tdata !== 10 * (k + 1) || pair_cnt !== k) begin
        bad++;
        $display("FAIL nom_pair%0d nv=%b wv=%b n=%0d w=%0d cnt=%0d want 1/1/%0d/%0d/%0d",
                 k, n_tvalid, w_tvalid, n_tdata, w_tdata, pair_cnt, k + 1, 10 * (k + 1), k);
      end
      $display("nominal: pair %0d n=%0d w=%0d", k, n_tdata, w_tdata);
      @(negedge aclk);
    end
    total++;
    if (done !== 1'b1 || pair_cnt !== 4 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL nom_done done=%b cnt=%0d busy=%b cmd_ready=%b want 1/4/0/1", done, pair_cnt, busy, cmd_ready);
    end
    @(negedge aclk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL nom_done_pulse done=%b want=0", done);
    end
  endtask

  task automatic test_skew();
    n_tready = 1; w_tready = 0; cfg_tready = 1;
    push_a(5);
    push_b(50);
    send_cmd(1, 32'h4000_0000);
    @(negedge aclk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (n_tvalid !== (i == 0) || w_tvalid !== 1'b1 || w_tdata !== 50 || pair_cnt !== 0) begin
        bad++;
        $display("FAIL skew_c%0d nv=%b wv=%b w=%0d cnt=%0d want %b/1/50/0",
                 i, n_tvalid, w_tvalid, w_tdata, pair_cnt, (i == 0));
      end
      if (i == 0) begin
        total++;
        if (n_tdata !== 5) begin
          bad++;
          $display("FAIL skew_ndata got=%0d want=5", n_tdata);
        end
      end
      $display("skew: cycle %0d nv=%b wv=%b", i, n_tvalid, w_tvalid);
      if (i < 2) @(negedge aclk);
    end
    w_tready = 1;
    @(negedge aclk);
    total++;
    if (done !== 1'b1 || pair_cnt !== 1 || w_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL skew_done done=%b cnt=%0d wv=%b want 1/1/0", done, pair_cnt, w_tvalid);
    end
    @(negedge aclk);
  endtask

  task automatic test_fifo_full();
    n_tready = 1; w_tready = 1; cfg_tready = 1;
    for (int i = 0; i < 4; i++) push_a(100 + i);
    total++;
    if (a_tready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b want=0", a_tready);
    end
    push_b(200);
    a_tdata = 104;
    a_tvalid = 1;
    @(negedge aclk);
    total++;
    if (a_tready !== 1'b0) begin
      bad++;
      $display("FAIL full_hold got=%b want=0", a_tready);
    end
    send_cmd(1, 32'h1);
    @(negedge aclk);
    total++;
    if (n_tdata !== 100 || w_tdata !== 200 || n_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL full_pop n=%0d w=%0d nv=%b want 100/200/1", n_tdata, w_tdata, n_tvalid);
    end
    @(negedge aclk);
    total++;
    if (done !== 1'b1 || a_tready !== 1'b1) begin
      bad++;
      $display("FAIL full_space done=%b a_tready=%b want 1/1", done, a_tready);
    end
    @(negedge aclk);
    a_tvalid = 0;
    total++;
    if (a_tready !== 1'b0) begin
      bad++;
      $display("FAIL full_refill a_tready=%b want=0", a_tready);
    end
    $display("fifo_full: held word offered, a_tready=%b", a_tready);
    // Drain: the held word must appear last.
    for (int i = 1; i <= 4; i++) push_b(200 + i);
    send_cmd(4, 32'h2);
    @(negedge aclk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (n_tdata !== 101 + k || w_tdata !== 201 + k || n_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL drain%0d n=%0d w=%0d nv=%b want %0d/%0d/1", k, n_tdata, w_tdata, n_tvalid, 101 + k, 201 + k);
      end
      @(negedge aclk);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL drain_done done=%b want=1", done);
    end
    @(negedge aclk);
  endtask

  task automatic test_empty_job();
    n_tready = 1; w_tready = 1; cfg_tready = 1;
    push_a(9);
    push_b(90);
    send_cmd(0, 32'h7);
    total++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== 32'h7 || n_tvalid !== 1'b0 || w_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL empty_cfg cv=%b cd=%0h nv=%b wv=%b want 1/7/0/0", cfg_tvalid, cfg_tdata, n_tvalid, w_tvalid);
    end
    @(negedge aclk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || n_tvalid !== 1'b0 || w_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL empty_done done=%b busy=%b nv=%b wv=%b want 1/0/0/0", done, busy, n_tvalid, w_tvalid);
    end
    $display("empty_job: done=%b", done);
    @(negedge aclk);
    send_cmd(1, 32'h8);
    @(negedge aclk);
    total++;
    if (n_tdata !== 9 || w_tdata !== 90) begin
      bad++;
      $display("FAIL empty_kept n=%0d w=%0d want 9/90", n_tdata, w_tdata);
    end
    @(negedge aclk);
    @(negedge aclk);
  endtask

  task automatic test_reset_mid_job();
    n_tready = 1; w_tready = 1; cfg_tready = 1;
    for (int i = 0; i < 4; i++) push_a(21 + i);
    for (int i = 0; i < 4; i++) push_b(31 + i);
    send_cmd(4, 32'h5);
    @(negedge aclk);
    @(negedge aclk);
    @(negedge aclk);
    total++;
    if (pair_cnt !== 2) begin
      bad++;
      $display("FAIL mid_cnt got=%0d want=2", pair_cnt);
    end
    areset = 1;
    @(negedge aclk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pair_cnt !== 0 || n_tvalid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b cnt=%0d nv=%b cmd_ready=%b want 0/0/0/0/0",
               busy, done, pair_cnt, n_tvalid, cmd_ready);
    end
    areset = 0;
    @(negedge aclk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || a_tready !== 1'b1) begin
      bad++;
      $display("FAIL mid_after done=%b cmd_ready=%b a_tready=%b want 0/1/1", done, cmd_ready, a_tready);
    end
    push_a(77);
    push_b(88);
    send_cmd(1, 32'h9);
    @(negedge aclk);
    total++;
    if (n_tdata !== 77 || w_tdata !== 88 || n_tvalid !== 1'b1 || w_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_newjob n=%0d w=%0d nv=%b wv=%b want 77/88/1/1", n_tdata, w_tdata, n_tvalid, w_tvalid);
    end
    @(negedge aclk);
    total++;
    if (done !== 1'b1 || pair_cnt !== 1) begin
      bad++;
      $display("FAIL mid_newdone done=%b cnt=%0d want 1/1", done, pair_cnt);
    end
    $display("reset_mid_job: new job done=%b cnt=%0d", done, pair_cnt);
    @(negedge aclk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_skew();
    test_fifo_full();
    test_empty_job();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
